shot_fire_controller: RTL and testbench
=======================================

Name: shot_fire_controller

Overview:
- Sequences player fire requests onto the three shot slots, decoupling button handling from the shot stock datapath.
- Edge-detects fire, enforces a per-shot cooldown and a finite ammo magazine with timed reload, and supports a multi-shot burst power-up.
- Allocates shots round-robin across free slots.
- Sits between the player input/power-up logic and the shot slot trigger inputs; all timing is in frames counted on startOfFrame.

Parameters:
- NUM_SLOTS, 3, number of shot slots; fixed at 3 in this revision.
- MAX_AMMO, 8, magazine size, 1..15.
- COOLDOWN_FRAMES, 4, frames between single shots, >=1.
- RELOAD_FRAMES, 60, frames to refill the magazine, >=1.
- BURST_COUNT, 3, shots per burst, 1..7.
- BURST_GAP_FRAMES, 2, frames between burst shots, >=1.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, asynchronous active-low reset.
- startOfFrame, input, 1, one-cycle pulse per video frame.
- pause, input, 1, freezes all frame counters and blocks firing.
- fireBtn, input, 1, player fire level; a rising edge requests one shot.
- burstReq, input, 1, one-cycle pulse that starts a burst.
- shotDirection, input, 3, current aim, passed through to the fired shot.
- slotBusy, input, 3, per-slot enable fed back from the shot movers.
- triggerSlot, output, 3, one-hot one-cycle fire pulse to a slot.
- triggerDir, output, 3, direction for the fired shot; valid with triggerSlot.
- nonAvailable, output, 1, one-cycle pulse when a request is refused.
- ammoCount, output, 4, rounds remaining.
- reloading, output, 1, high while in RELOAD.
- busy, output, 1, high when state is not IDLE.

Behaviour:
- Reset (async, resetN=0), all registered:
  - triggerSlot=0, triggerDir=0, nonAvailable=0, reloading=0, busy=0.
  - ammoCount=MAX_AMMO, state=IDLE, pending=0, rrPtr=0.
  - fireBtn history=0, all counters=0.
  - Reset mid-burst or mid-reload abandons it with no residual pulse.
- Fire edge: fireEdge = fireBtn & ~fireBtn_d.
  - fireBtn_d updates every cycle, including during pause, so releasing pause with the button held does not fire.
- Latency: a request sampled at edge N produces its triggerSlot pulse at edge N+1, exactly 1 cycle wide. triggerDir is the shotDirection sampled at edge N.
- Slot choice: first free slot (slotBusy bit = 0) scanning rrPtr, rrPtr+1, rrPtr+2 mod 3. After a fire, rrPtr = chosen slot + 1 mod 3.
- No free slot: nonAvailable pulses, no ammo is consumed, state is unchanged.
- A frame tick means startOfFrame & ~pause. While pause=1:
  - no triggers are issued;
  - fireEdge and burstReq are dropped;
  - counters hold.
- Every fire decrements ammoCount by 1. It never underflows.
- States:
  - IDLE:
    - burstReq (has priority over fireEdge in the same cycle): if ammo>0, fire the first burst shot, set burstLeft=BURST_COUNT-1, gapCnt=BURST_GAP_FRAMES, go to BURST (or COOLDOWN if burstLeft=0).
    - Otherwise fireEdge: if ammo>0 and a slot is free, fire, set cdCnt=COOLDOWN_FRAMES, go to COOLDOWN.
    - After either fire, if ammo becomes 0, go to RELOAD instead, with rlCnt=RELOAD_FRAMES.
  - COOLDOWN:
    - fireEdge sets pending=1 (one-deep; further edges are discarded).
    - Each frame tick decrements cdCnt. When cdCnt goes 1->0, go to IDLE.
    - A pending request is served on the first IDLE cycle as if it were a fireEdge, and pending then clears.
  - BURST:
    - Each frame tick decrements gapCnt. At 1->0, fire the next shot and reload gapCnt.
    - If no slot is free, that shot is skipped, nonAvailable pulses, and burstLeft still decrements.
    - When burstLeft reaches 0, go to COOLDOWN.
    - If ammo hits 0, the burst ends and the block goes to RELOAD.
    - fireEdge is ignored; burstReq is ignored.
  - RELOAD:
    - reloading=1.
    - fireEdge or burstReq pulses nonAvailable and is not queued; pending clears on entry.
    - Each frame tick decrements rlCnt. At 1->0, ammoCount=MAX_AMMO and go to IDLE.
- If startOfFrame and a request coincide, both take effect in the same edge.

Test Plan:
- After reset, check ammoCount=8 and busy=0. Raise fireBtn at cycle 10 with slotBusy=000 and shotDirection=3'd2 -> triggerSlot=001 for one cycle at cycle 11, triggerDir=2, ammoCount=7, busy=1. After 4 frame ticks, IDLE.
- Fire twice with cooldown in between, driving slotBusy to mirror the fired slots -> slots 001 then 010. With slotBusy=111, a third edge -> nonAvailable pulse, ammoCount unchanged.
- Fire 8 times with cooldown respected -> the 8th shot enters RELOAD and reloading=1. A fireEdge during reload -> nonAvailable, no trigger. After 60 frame ticks, ammoCount=8 and IDLE.
- burstReq and fireEdge in the same cycle with ammo=8 -> three triggers spaced 2 frames apart in slots 001, 010, 100, ammoCount=5, then COOLDOWN.
- Burst with ammo=2 -> two shots fired, then RELOAD. Hold pause=1 for 10 frames during reload -> rlCnt frozen and no triggers. Release pause with fireBtn held high -> no fire.
- Assert resetN=0 mid-burst after 1 shot -> all outputs at reset values on the same cycle and ammoCount=8. No trigger pulse appears after release.

Source files
------------

// File: rtl/shot_fire_controller.sv
// shot_fire_controller
//   Turns player fire requests (single shots and bursts) into one-cycle
//   trigger pulses for three shot slots. Handles fire-button edge detection,
//   a per-shot cooldown, a finite magazine with timed reload and round-robin
//   slot allocation. All timing is counted in frame ticks
//   (startOfFrame while not paused).
//
// Ports
//   clk, resetN      clock, asynchronous active-low reset
//   startOfFrame     one-cycle pulse per video frame
//   pause            freezes frame counters and blocks firing
//   fireBtn          fire level; a rising edge requests one shot
//   burstReq         one-cycle pulse requesting a burst
//   shotDirection    current aim, forwarded with the fired shot
//   slotBusy         per-slot busy feedback from the shot movers
//   triggerSlot      one-hot, one-cycle fire pulse to a slot
//   triggerDir       direction for the fired shot, valid with triggerSlot
//   nonAvailable     one-cycle pulse when a request is refused
//   ammoCount        rounds remaining
//   reloading        high while reloading
//   busy             high whenever the controller is not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready; serves burst, fire edge or a pending request
// S_COOLDOWN | waiting cdCnt frames after a shot; one fire edge may queue
// S_BURST    | firing remaining burst shots every BURST_GAP_FRAMES frames
// S_RELOAD   | magazine empty; refilled after RELOAD_FRAMES frames
`timescale 1ns/1ps

module shot_fire_controller #(
  parameter int NUM_SLOTS        = 3,
  parameter int MAX_AMMO         = 8,
  parameter int COOLDOWN_FRAMES  = 4,
  parameter int RELOAD_FRAMES    = 60,
  parameter int BURST_COUNT      = 3,
  parameter int BURST_GAP_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 pause,
  input  logic                 fireBtn,
  input  logic                 burstReq,
  input  logic [2:0]           shotDirection,
  input  logic [NUM_SLOTS-1:0] slotBusy,
  output logic [NUM_SLOTS-1:0] triggerSlot,
  output logic [2:0]           triggerDir,
  output logic                 nonAvailable,
  output logic [3:0]           ammoCount,
  output logic                 reloading,
  output logic                 busy
);

  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);
  localparam int RL_W  = $clog2(RELOAD_FRAMES + 1);
  localparam int GAP_W = $clog2(BURST_GAP_FRAMES + 1);
  localparam int BL_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COOLDOWN = 2'd1,
    S_BURST    = 2'd2,
    S_RELOAD   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [3:0]           ammo_q, ammo_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [BL_W-1:0]      burst_left_q, burst_left_d;
  logic [RL_W-1:0]      rl_cnt_q, rl_cnt_d;
  logic                 fire_btn_q, fire_btn_d;
  logic [NUM_SLOTS-1:0] trigger_slot_q, trigger_slot_d;
  logic [2:0]           trigger_dir_q, trigger_dir_d;
  logic                 non_avail_q, non_avail_d;

  logic                 fire_edge, burst_v, frame_tick, fire_req;
  logic                 slot_found;
  logic [1:0]           slot_sel;
  logic [2:0]           scan_idx;
  logic                 shoot;

  // Requests are dropped outright while paused; the button history still
  // tracks the level so a button held across pause release is not an edge.
  assign fire_edge  = fireBtn & ~fire_btn_q & ~pause;
  assign burst_v    = burstReq & ~pause;
  assign frame_tick = startOfFrame & ~pause;
  assign fire_req   = fire_edge | (pending_q & ~pause);
  assign fire_btn_d = fireBtn;

  // First free slot starting at the round-robin pointer.
  always_comb begin
    slot_found = 1'b0;
    slot_sel   = 2'd0;
    scan_idx   = 3'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 3'(k);
      if (scan_idx >= 3'(NUM_SLOTS)) scan_idx = scan_idx - 3'(NUM_SLOTS);
      if (!slot_found && !slotBusy[scan_idx[1:0]]) begin
        slot_found = 1'b1;
        slot_sel   = scan_idx[1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    ammo_d         = ammo_q;
    rr_ptr_d       = rr_ptr_q;
    cd_cnt_d       = cd_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    burst_left_d   = burst_left_q;
    rl_cnt_d       = rl_cnt_q;
    trigger_slot_d = '0;
    trigger_dir_d  = 3'd0;
    non_avail_d    = 1'b0;
    shoot          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (burst_v) begin
          // a burst swallows a coincident fire edge and any pending request
          pending_d = 1'b0;
          if (ammo_q != 4'd0 && slot_found) begin
            shoot = 1'b1;
            if (ammo_q == 4'd1) begin
              state_d  = S_RELOAD;
              rl_cnt_d = RL_W'(RELOAD_FRAMES);
            end else if (BURST_COUNT == 1) begin
              state_d  = S_COOLDOWN;
              cd_cnt_d = CD_W'(COOLDOWN_FRAMES);
            end else begin
              state_d      = S_BURST;
              burst_left_d = BL_W'(BURST_COUNT - 1);
              gap_cnt_d    = GAP_W'(BURST_GAP_FRAMES);
            end
          end else begin
            non_avail_d = 1'b1;
          end
        end else if (fire_req) begin
          pending_d = 1'b0;
          if (ammo_q != 4'd0 && slot_found) begin
            shoot = 1'b1;
            if (ammo_q == 4'd1) begin
              state_d  = S_RELOAD;
              rl_cnt_d = RL_W'(RELOAD_FRAMES);
            end else begin
              state_d  = S_COOLDOWN;
              cd_cnt_d = CD_W'(COOLDOWN_FRAMES);
            end
          end else begin
            non_avail_d = 1'b1;
          end
        end
      end

      S_COOLDOWN: begin
        if (fire_edge) pending_d = 1'b1;
        if (frame_tick) begin
          cd_cnt_d = cd_cnt_q - CD_W'(1);
          if (cd_cnt_q == CD_W'(1)) state_d = S_IDLE;
        end
      end

      S_BURST: begin
        if (frame_tick) begin
          if (gap_cnt_q == GAP_W'(1)) begin
            gap_cnt_d    = GAP_W'(BURST_GAP_FRAMES);
            burst_left_d = burst_left_q - BL_W'(1);
            // a blocked burst shot is skipped but still counts
            if (ammo_q != 4'd0 && slot_found) shoot = 1'b1;
            else                               non_avail_d = 1'b1;
            if (shoot && ammo_q == 4'd1) begin
              state_d  = S_RELOAD;
              rl_cnt_d = RL_W'(RELOAD_FRAMES);
            end else if (burst_left_q == BL_W'(1)) begin
              state_d  = S_COOLDOWN;
              cd_cnt_d = CD_W'(COOLDOWN_FRAMES);
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end

      S_RELOAD: begin
        pending_d = 1'b0;
        if (fire_edge || burst_v) non_avail_d = 1'b1;
        if (frame_tick) begin
          rl_cnt_d = rl_cnt_q - RL_W'(1);
          if (rl_cnt_q == RL_W'(1)) begin
            ammo_d  = 4'(MAX_AMMO);
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (shoot) begin
      trigger_slot_d = NUM_SLOTS'(1) << slot_sel;
      trigger_dir_d  = shotDirection;
      ammo_d         = ammo_q - 4'd1;
      rr_ptr_d       = (slot_sel == 2'(NUM_SLOTS - 1)) ? 2'd0 : slot_sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      pending_q      <= 1'b0;
      ammo_q         <= 4'(MAX_AMMO);
      rr_ptr_q       <= 2'd0;
      cd_cnt_q       <= '0;
      gap_cnt_q      <= '0;
      burst_left_q   <= '0;
      rl_cnt_q       <= '0;
      fire_btn_q     <= 1'b0;
      trigger_slot_q <= '0;
      trigger_dir_q  <= 3'd0;
      non_avail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      ammo_q         <= ammo_d;
      rr_ptr_q       <= rr_ptr_d;
      cd_cnt_q       <= cd_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      burst_left_q   <= burst_left_d;
      rl_cnt_q       <= rl_cnt_d;
      fire_btn_q     <= fire_btn_d;
      trigger_slot_q <= trigger_slot_d;
      trigger_dir_q  <= trigger_dir_d;
      non_avail_q    <= non_avail_d;
    end
  end

  assign triggerSlot  = trigger_slot_q;
  assign triggerDir   = trigger_dir_q;
  assign nonAvailable = non_avail_q;
  assign ammoCount    = ammo_q;
  assign reloading    = (state_q == S_RELOAD);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_shot_fire_controller.sv
`timescale 1ns/1ps

module tb_shot_fire_controller;

  localparam int MAX_AMMO = 8;
  localparam int CD_F     = 4;
  localparam int RL_F     = 60;
  localparam int BURST_N  = 3;
  localparam int GAP_F    = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       pause = 1'b0;
  logic       fireBtn = 1'b0;
  logic       burstReq = 1'b0;
  logic [2:0] shotDirection = 3'd0;
  logic [2:0] slotBusy = 3'd0;
  logic [2:0] triggerSlot;
  logic [2:0] triggerDir;
  logic       nonAvailable;
  logic [3:0] ammoCount;
  logic       reloading;
  logic       busy;

  shot_fire_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pause        (pause),
    .fireBtn      (fireBtn),
    .burstReq     (burstReq),
    .shotDirection(shotDirection),
    .slotBusy     (slotBusy),
    .triggerSlot  (triggerSlot),
    .triggerDir   (triggerDir),
    .nonAvailable (nonAvailable),
    .ammoCount    (ammoCount),
    .reloading    (reloading),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: activity names rather than an encoded state register.
  typedef enum {M_READY, M_COOL, M_BURSTING, M_RELOADING} activity_t;
  activity_t m_act;
  int m_ammo, m_pend, m_rr, m_cool_left, m_gap_left, m_burst_left, m_reload_left, m_prev_btn;
  int e_trig, e_dir, e_na;

  task automatic model_reset();
    m_act = M_READY; m_ammo = MAX_AMMO; m_pend = 0; m_rr = 0;
    m_cool_left = 0; m_gap_left = 0; m_burst_left = 0; m_reload_left = 0;
    m_prev_btn = 0; e_trig = 0; e_dir = 0; e_na = 0;
  endtask

  function automatic int free_slot();
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (!slotBusy[s]) return s;
    end
    return -1;
  endfunction

  task automatic shoot(input int s);
    e_trig = 1 << s;
    e_dir  = int'(shotDirection);
    m_ammo = m_ammo - 1;
    m_rr   = (s + 1) % 3;
  endtask

  task automatic after_shot_single();
    if (m_ammo == 0) begin m_act = M_RELOADING; m_reload_left = RL_F; end
    else begin m_act = M_COOL; m_cool_left = CD_F; end
  endtask

  task automatic model_step();
    bit tick, edge_seen, breq;
    int s;
    tick      = startOfFrame && !pause;
    edge_seen = fireBtn && (m_prev_btn == 0) && !pause;
    breq      = burstReq && !pause;
    m_prev_btn = int'(fireBtn);
    e_trig = 0; e_dir = 0; e_na = 0;
    s = free_slot();
    case (m_act)
      M_READY: begin
        if (breq) begin
          m_pend = 0;
          if (m_ammo > 0 && s >= 0) begin
            shoot(s);
            if (m_ammo == 0) begin m_act = M_RELOADING; m_reload_left = RL_F; end
            else if (BURST_N == 1) begin m_act = M_COOL; m_cool_left = CD_F; end
            else begin m_act = M_BURSTING; m_burst_left = BURST_N - 1; m_gap_left = GAP_F; end
          end else e_na = 1;
        end else if (edge_seen || (m_pend != 0 && !pause)) begin
          m_pend = 0;
          if (m_ammo > 0 && s >= 0) begin shoot(s); after_shot_single(); end
          else e_na = 1;
        end
      end
      M_COOL: begin
        if (edge_seen) m_pend = 1;
        if (tick) begin
          m_cool_left--;
          if (m_cool_left == 0) m_act = M_READY;
        end
      end
      M_BURSTING: begin
        if (tick) begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_gap_left = GAP_F;
            m_burst_left--;
            if (m_ammo > 0 && s >= 0) shoot(s); else e_na = 1;
            if (m_ammo == 0) begin m_act = M_RELOADING; m_reload_left = RL_F; end
            else if (m_burst_left == 0) begin m_act = M_COOL; m_cool_left = CD_F; end
          end
        end
      end
      M_RELOADING: begin
        m_pend = 0;
        if (edge_seen || breq) e_na = 1;
        if (tick) begin
          m_reload_left--;
          if (m_reload_left == 0) begin m_ammo = MAX_AMMO; m_act = M_READY; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check_val("triggerSlot", triggerSlot, e_trig);
    check_val("triggerDir", triggerDir, e_dir);
    check_val("nonAvailable", nonAvailable, e_na);
    check_val("ammoCount", ammoCount, m_ammo);
    check_val("reloading", reloading, (m_act == M_RELOADING) ? 1 : 0);
    check_val("busy", busy, (m_act != M_READY) ? 1 : 0);
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; cycle();
      startOfFrame = 1'b0; cycle();
    end
  endtask

  task automatic press();
    fireBtn = 1'b0; cycle();
    fireBtn = 1'b1; cycle();
  endtask

  task automatic do_reset();
    resetN = 1'b0; fireBtn = 1'b0; burstReq = 1'b0; startOfFrame = 1'b0; pause = 1'b0;
    #1;
    check_val("rst_trig", triggerSlot, 0);
    check_val("rst_dir", triggerDir, 0);
    check_val("rst_na", nonAvailable, 0);
    check_val("rst_ammo", ammoCount, MAX_AMMO);
    check_val("rst_reloading", reloading, 0);
    check_val("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single shot, latency, direction, cooldown length
    for (int i = 0; i < 9; i++) cycle();
    shotDirection = 3'd2; fireBtn = 1'b1; cycle();
    check_val("tp1_slot", triggerSlot, 3'b001);
    check_val("tp1_dir", triggerDir, 2);
    check_val("tp1_ammo", ammoCount, 7);
    check_val("tp1_busy", busy, 1);
    cycle();
    check_val("tp1_pulse_width", triggerSlot, 0);
    frames(CD_F);
    check_val("tp1_idle", busy, 0);

    // round robin with busy feedback, then all slots busy
    slotBusy = 3'b001; press();
    check_val("tp2_slot", triggerSlot, 3'b010);
    frames(CD_F);
    slotBusy = 3'b111; press();
    check_val("tp2_refused", nonAvailable, 1);
    check_val("tp2_ammo", ammoCount, 6);
    slotBusy = 3'b000; cycle();

    // empty the magazine, fire during reload, reload completes
    do_reset();
    for (int i = 0; i < MAX_AMMO; i++) begin
      press();
      if (i < MAX_AMMO - 1) frames(CD_F);
    end
    check_val("tp3_reloading", reloading, 1);
    press();
    check_val("tp3_refused", nonAvailable, 1);
    check_val("tp3_no_trig", triggerSlot, 0);
    frames(RL_F);
    check_val("tp3_ammo_full", ammoCount, MAX_AMMO);
    check_val("tp3_idle", busy, 0);

    // burst wins over a simultaneous fire edge
    do_reset();
    fireBtn = 1'b0; cycle();
    fireBtn = 1'b1; burstReq = 1'b1; cycle();
    burstReq = 1'b0;
    check_val("tp4_first", triggerSlot, 3'b001);
    frames(GAP_F * (BURST_N - 1));
    check_val("tp4_ammo", ammoCount, 5);
    check_val("tp4_cooldown", busy, 1);
    frames(CD_F);

    // burst with two rounds left, paused reload, held button on release
    for (int i = 0; i < 3; i++) begin press(); frames(CD_F); end
    fireBtn = 1'b0; burstReq = 1'b1; cycle();
    burstReq = 1'b0;
    frames(GAP_F);
    check_val("tp5_empty", ammoCount, 0);
    check_val("tp5_reloading", reloading, 1);
    pause = 1'b1;
    frames(5); fireBtn = 1'b1; frames(5);
    pause = 1'b0;
    frames(RL_F - 1);
    check_val("tp5_frozen", reloading, 1);
    frames(1);
    check_val("tp5_done", ammoCount, MAX_AMMO);

    // reset in the middle of a burst
    fireBtn = 1'b0; burstReq = 1'b1; cycle();
    burstReq = 1'b0; cycle();
    do_reset();
    for (int i = 0; i < 8; i++) cycle();
    frames(4);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      startOfFrame  = ($urandom_range(0, 1) == 0);
      pause         = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) fireBtn = ~fireBtn;
      burstReq      = ($urandom_range(0, 24) == 0);
      shotDirection = 3'($urandom_range(0, 7));
      slotBusy      = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
